// File: rtl/control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch / execute / memory / writeback
// with memory handshakes, illegal-instruction detection and bus timeouts.
module control_fsm #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     instr,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [1:0]      mem_access_width,
  output logic            mem_unsigned,
  output logic [XLEN-1:0] imm,
  output logic            alu_imm,
  output logic            alu_a_zero,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic            pc_we,
  output logic            retired,
  output logic            halted,
  output logic [1:0]      halt_cause
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t        state, state_next;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  logic [1:0]    cause_next;
  logic          timeout_hit;

  logic [31:0]   imm32;
  logic          is_load, is_store, illegal, force_add;

  // Instruction decode is purely combinational from IR so it is valid in every state.
  always_comb begin
    imm32      = 32'd0;
    alu_imm    = 1'b0;
    alu_a_zero = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    illegal    = 1'b0;
    force_add  = 1'b0;
    case (ir[6:0])
      OP_IMM: begin
        alu_imm = 1'b1;
        imm32   = {{20{ir[31]}}, ir[31:20]};
      end
      OP_REG: begin
        alu_imm = 1'b0;
      end
      OP_LOAD: begin
        alu_imm   = 1'b1;
        is_load   = 1'b1;
        force_add = 1'b1;
        imm32     = {{20{ir[31]}}, ir[31:20]};
        illegal   = (ir[14:12] == 3'd3) || (ir[14:12] == 3'd6) || (ir[14:12] == 3'd7);
      end
      OP_STORE: begin
        alu_imm   = 1'b1;
        is_store  = 1'b1;
        force_add = 1'b1;
        imm32     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        illegal   = (ir[14:12] > 3'd2);
      end
      OP_LUI: begin
        alu_imm    = 1'b1;
        alu_a_zero = 1'b1;
        force_add  = 1'b1;
        imm32      = {ir[31:12], 12'd0};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm              = XLEN'($signed(imm32));
  assign alu_funct3       = force_add ? 3'd0 : ir[14:12];
  assign alu_funct7       = force_add ? 7'd0 : ir[31:25];
  assign mem_access_width = ir[13:12];
  assign mem_unsigned     = ir[14];
  assign rf_wsel          = is_load;

  // The wait counter reaching TIMEOUT-1 means this is the last permitted request cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      ir         <= 32'h0000_0013;
      cnt        <= '0;
      halt_cause <= 2'd0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && imem_ack)
        ir <= instr;
      if (state_next != state)
        cnt <= '0;
      else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack))
        cnt <= cnt + CW'(1);
      if (state_next == S_HALT && state != S_HALT)
        halt_cause <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = 2'd0;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_EXEC;
        end else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = CAUSE_IMEM;
        end
      end
      S_EXEC: begin
        if (illegal) begin
          state_next = S_HALT;
          cause_next = CAUSE_ILLEGAL;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = is_load ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_HALT;
          cause_next = CAUSE_DMEM;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // Requests are gated by rst_n so an in-flight handshake drops the moment reset asserts.
  always_comb begin
    imem_req = rst_n && (state == S_FETCH);
    dmem_req = rst_n && (state == S_MEM);
    dmem_we  = (state == S_MEM) && is_store;
    rf_we    = (state == S_WB);
    pc_we    = (state == S_WB) || (state == S_MEM && dmem_ack && is_store);
    retired  = pc_we;
    halted   = (state == S_HALT);
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm (XLEN=64, TIMEOUT=4) with a retirement scoreboard.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [1:0]  mem_access_width;
  logic        mem_unsigned;
  logic [63:0] imm;
  logic        alu_imm, alu_a_zero;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        rf_we, rf_wsel, pc_we, retired, halted;
  logic [1:0]  halt_cause;

  typedef struct packed {
    logic rf_we;
    logic rf_wsel;
  } retire_t;

  retire_t exp_q[$];
  int      errors = 0;
  int      checks = 0;

  control_fsm #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .mem_access_width(mem_access_width), .mem_unsigned(mem_unsigned),
    .imm(imm), .alu_imm(alu_imm), .alu_a_zero(alu_a_zero),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .pc_we(pc_we), .retired(retired),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change just after the rising edge (releasing reset too), outputs are read at the falling edge.
  task automatic applyStimulus(input logic iack, input logic [31:0] ins, input logic dack);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    imem_ack = iack;
    instr    = ins;
    dmem_ack = dack;
    @(negedge clk);
  endtask

  // Every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pc_we_eq_retired", pc_we, retired);
      checkOutput("rf_we_without_retire", rf_we & ~retired, 1'b0);
      if (retired === 1'b1) begin
        checkOutput("retire_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          retire_t e;
          e = exp_q.pop_front();
          checkOutput("retire_rf_we", rf_we, e.rf_we);
          checkOutput("retire_rf_wsel", rf_wsel, e.rf_wsel);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_imem_req", imem_req, 1'b0);
    checkOutput("rst_dmem_req", dmem_req, 1'b0);
    checkOutput("rst_rf_we", rf_we, 1'b0);
    checkOutput("rst_pc_we", pc_we, 1'b0);
    checkOutput("rst_retired", retired, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_cause", halt_cause, 2'd0);
    checkOutput("rst_nop_imm", imm, 64'd0);
    checkOutput("rst_nop_alu_imm", alu_imm, 1'b1);

    // addi x1,x0,5
    exp_q.push_back(retire_t'{1'b1, 1'b0});
    applyStimulus(1'b1, 32'h0050_0093, 1'b0);
    checkOutput("addi_c1_imem_req", imem_req, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("addi_exec_imem_req", imem_req, 1'b0);
    checkOutput("addi_imm", imm, 64'd5);
    checkOutput("addi_alu_imm", alu_imm, 1'b1);
    checkOutput("addi_exec_rf_we", rf_we, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("addi_wb_rf_we", rf_we, 1'b1);
    checkOutput("addi_wb_retired", retired, 1'b1);

    // sub x1,x2,x3; a stray dmem_ack must be ignored
    exp_q.push_back(retire_t'{1'b1, 1'b0});
    applyStimulus(1'b1, 32'h4031_00B3, 1'b0);
    checkOutput("c4_imem_req", imem_req, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("sub_alu_imm", alu_imm, 1'b0);
    checkOutput("sub_imm", imm, 64'd0);
    checkOutput("sub_funct7", alu_funct7, 7'h20);
    checkOutput("sub_funct3", alu_funct3, 3'd0);
    checkOutput("sub_dmem_req", dmem_req, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("sub_wb_rf_we", rf_we, 1'b1);

    // sw with two data wait cycles
    exp_q.push_back(retire_t'{1'b0, 1'b0});
    applyStimulus(1'b1, 32'hFE11_2E23, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("sw_funct3", alu_funct3, 3'd0);
    checkOutput("sw_alu_imm", alu_imm, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("sw_wait_dmem_req", dmem_req, 1'b1);
      checkOutput("sw_wait_dmem_we", dmem_we, 1'b1);
      checkOutput("sw_wait_retired", retired, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("sw_ack_retired", retired, 1'b1);
    checkOutput("sw_ack_rf_we", rf_we, 1'b0);

    // lbu, zero-wait memory
    exp_q.push_back(retire_t'{1'b1, 1'b1});
    applyStimulus(1'b1, 32'h0001_4183, 1'b0);
    checkOutput("lbu_fetch_after_store", imem_req, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("lbu_unsigned", mem_unsigned, 1'b1);
    checkOutput("lbu_width", mem_access_width, 2'd0);
    checkOutput("lbu_funct3_add", alu_funct3, 3'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("lbu_mem_dmem_req", dmem_req, 1'b1);
    checkOutput("lbu_mem_dmem_we", dmem_we, 1'b0);
    checkOutput("lbu_mem_retired", retired, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("lbu_wb_rf_we", rf_we, 1'b1);
    checkOutput("lbu_wb_rf_wsel", rf_wsel, 1'b1);

    // LUI, positive and negative upper immediates
    exp_q.push_back(retire_t'{1'b1, 1'b0});
    applyStimulus(1'b1, 32'h1234_50B7, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("lui_imm", imm, 64'h0000_0000_1234_5000);
    checkOutput("lui_a_zero", alu_a_zero, 1'b1);
    checkOutput("lui_funct7", alu_funct7, 7'd0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    exp_q.push_back(retire_t'{1'b1, 1'b0});
    applyStimulus(1'b1, 32'h8000_00B7, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("lui_neg_imm", imm, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Fetch ack on the 4th (last permitted) request cycle
    exp_q.push_back(retire_t'{1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("tmo_wait_imem_req", imem_req, 1'b1);
    end
    applyStimulus(1'b1, 32'h0050_0093, 1'b0);
    checkOutput("tmo_last_imem_req", imem_req, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("tmo_accept_exec", imem_req, 1'b0);
    checkOutput("tmo_accept_halted", halted, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Reset in the middle of a store handshake; the late ack is ignored
    applyStimulus(1'b1, 32'hFE11_2E23, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("midrst_dmem_req_before", dmem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_dmem_req_drop", dmem_req, 1'b0);
    checkOutput("midrst_imem_req_drop", imem_req, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("late_ack_imem_req", imem_req, 1'b1);
    checkOutput("late_ack_dmem_req", dmem_req, 1'b0);
    checkOutput("late_ack_retired", retired, 1'b0);

    // Fetch timeout: that was request cycle 1, three more without ack, then halt
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("itmo_wait_halted", halted, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("itmo_halted", halted, 1'b1);
    checkOutput("itmo_cause", halt_cause, 2'd2);
    checkOutput("itmo_imem_req", imem_req, 1'b0);
    applyStimulus(1'b1, 32'h0050_0093, 1'b0);
    checkOutput("itmo_absorb_imem_req", imem_req, 1'b0);
    checkOutput("itmo_absorb_halted", halted, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("itmo_async_clear", halted, 1'b0);

    // Data timeout on lw
    applyStimulus(1'b1, 32'h0000_A183, 1'b0);
    checkOutput("dtmo_fetch_req", imem_req, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("dtmo_wait_dmem_req", dmem_req, 1'b1);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("dtmo_halted", halted, 1'b1);
    checkOutput("dtmo_cause", halt_cause, 2'd3);
    checkOutput("dtmo_dmem_req", dmem_req, 1'b0);
    #2 rst_n = 1'b0;

    // Illegal opcode 0x7F
    applyStimulus(1'b1, 32'h0000_007F, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("ill_exec_halted", halted, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("ill_halted", halted, 1'b1);
    checkOutput("ill_cause", halt_cause, 2'd1);
    checkOutput("ill_imem_req", imem_req, 1'b0);
    #2 rst_n = 1'b0;

    // Illegal load funct3=7
    applyStimulus(1'b1, 32'h0000_7183, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("ld7_halted", halted, 1'b1);
    checkOutput("ld7_cause", halt_cause, 2'd1);
    checkOutput("ld7_retired", retired, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ld7_async_halted", halted, 1'b0);
    checkOutput("ld7_async_cause", halt_cause, 2'd0);

    #10;
    checkOutput("scoreboard_empty", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
